// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// operation-type constants and per-operation iteration counts.
package multdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_MULT_RUN = 3'd2,
    S_DIV_RUN  = 3'd3,
    S_FIX      = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int MULT_ITERS = 16;
  localparam int DIV_ITERS  = 32;

  // A request is valid only when exactly one of the two start strobes is set.
  function automatic logic valid_req(input logic m, input logic d);
    return m ^ d;
  endfunction

endpackage

// File: rtl/multdiv_sequencer.sv
// Control sequencer for an iterative 32-bit multiply/divide datapath.
// Walks IDLE -> LOAD -> {MULT_RUN | DIV_RUN} -> FIX -> DONE; the iteration
// counter itself lives in the parent and reports back through ovf16/ovf32.
// All outputs are registered, decoded from the next state.
// Optional build macro: MULTDIV_DIVZERO_FAST_EN -- a divide by zero skips the
// iterations and goes straight from LOAD to DONE with the exception set.
// FIX_CYCLES is legal in 1..3.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int FIX_CYCLES = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic ctrl_MULT,
  input  logic ctrl_DIV,
  input  logic divisor_zero,
  input  logic mult_ovf,
  input  logic ovf16,
  input  logic ovf32,
  output logic counter_enable,
  output logic counter_reset,
  output logic load_operands,
  output logic step_mult,
  output logic step_div,
  output logic sign_fix,
  output logic busy,
  output logic data_resultRDY,
  output logic data_exception
);

  localparam logic [1:0] FIX_LAST = 2'(FIX_CYCLES - 1);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic       dz_q, dz_d;
  logic       exc_q, exc_d;
  logic [1:0] fix_q, fix_d;
  logic       start;

  assign start          = valid_req(ctrl_MULT, ctrl_DIV);
  assign data_exception = exc_q;

  // Next-state logic; a valid request in any state (including busy ones)
  // restarts at LOAD, which is how an in-flight operation gets aborted.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dz_d    = dz_q;
    exc_d   = exc_q;
    fix_d   = fix_q;
    if (start) begin
      state_d = S_LOAD;
      op_d    = ctrl_DIV ? OP_DIV : OP_MULT;
      exc_d   = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          dz_d    = divisor_zero;
          fix_d   = 2'd0;
          state_d = (op_q == OP_DIV) ? S_DIV_RUN : S_MULT_RUN;
`ifdef MULTDIV_DIVZERO_FAST_EN
          if (op_q == OP_DIV && divisor_zero) begin
            state_d = S_DONE;
            exc_d   = 1'b1;
          end
`endif
        end
        S_MULT_RUN: begin
          fix_d = 2'd0;
          if (ovf16) state_d = S_FIX;
        end
        S_DIV_RUN: begin
          fix_d = 2'd0;
          if (ovf32) state_d = S_FIX;
        end
        S_FIX: begin
          if (fix_q == FIX_LAST) begin
            state_d = S_DONE;
            // Multiply overflow is only meaningful once sign correction ends.
            exc_d   = (op_q == OP_MULT) ? mult_ovf : dz_q;
          end else begin
            fix_d = fix_q + 2'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, latched context and registered output strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      op_q           <= OP_MULT;
      dz_q           <= 1'b0;
      exc_q          <= 1'b0;
      fix_q          <= 2'd0;
      counter_enable <= 1'b0;
      counter_reset  <= 1'b1;
      load_operands  <= 1'b0;
      step_mult      <= 1'b0;
      step_div       <= 1'b0;
      sign_fix       <= 1'b0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      dz_q           <= dz_d;
      exc_q          <= exc_d;
      fix_q          <= fix_d;
      counter_enable <= (state_d == S_MULT_RUN) || (state_d == S_DIV_RUN);
      counter_reset  <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DONE);
      load_operands  <= (state_d == S_LOAD);
      step_mult      <= (state_d == S_MULT_RUN);
      step_div       <= (state_d == S_DIV_RUN);
      sign_fix       <= (state_d == S_FIX);
      busy           <= (state_d == S_LOAD) || (state_d == S_MULT_RUN) ||
                        (state_d == S_DIV_RUN) || (state_d == S_FIX);
      data_resultRDY <= (state_d == S_DONE);
    end
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have parameter FIX_CYCLES, default 1, giving the number of post-iteration sign-correction cycles; legal range 1..3.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports ctrl_MULT and ctrl_DIV, input, 1 bit each: single-cycle start requests.
REQ-005 SHALL have port divisor_zero, input, 1 bit: datapath flag, divisor == 0.
REQ-006 SHALL have port mult_ovf, input, 1 bit: datapath flag, product exceeds 32 bits signed.
REQ-007 SHALL have ports ovf16 and ovf32, input, 1 bit each: registered 16- and 32-iteration flags from the iteration counter.
REQ-008 SHALL have ports counter_enable and counter_reset, output, 1 bit each: iteration counter controls.
REQ-009 SHALL have ports load_operands, step_mult, step_div and sign_fix, output, 1 bit each: datapath strobes.
REQ-010 SHALL have ports busy, data_resultRDY and data_exception, output, 1 bit each: status signals.

Function
REQ-011 SHALL implement the FSM states IDLE, LOAD, MULT_RUN, DIV_RUN, FIX and DONE.
REQ-012 SHALL, in IDLE or DONE, go to LOAD when exactly one of ctrl_MULT or ctrl_DIV is 1, and latch the operation type.
REQ-013 SHALL ignore the request and make no state change when ctrl_MULT and ctrl_DIV are both 1.
REQ-014 SHALL, in LOAD, assert load_operands and counter_reset for exactly one cycle, latch divisor_zero, then go to MULT_RUN or DIV_RUN.
REQ-015 SHALL, in MULT_RUN, assert counter_enable and step_mult, and go to FIX on the first rising edge where ovf16 = 1 (16 steps).
REQ-016 SHALL, in DIV_RUN, assert counter_enable and step_div, and go to FIX on the first rising edge where ovf32 = 1 (32 steps).
REQ-017 SHALL, in FIX, assert sign_fix for FIX_CYCLES cycles, then go to DONE.
REQ-018 SHALL, in DONE, hold data_resultRDY = 1 for exactly one cycle, then go to IDLE unless a new request is present.
REQ-019 SHALL drive data_exception as follows: for a multiply, mult_ovf sampled on the last FIX cycle; for a divide, the latched divisor_zero.
REQ-020 SHALL hold data_exception stable from DONE until the next LOAD, and clear it in LOAD.
REQ-021 SHALL drive busy = 1 in LOAD, RUN and FIX, and busy = 0 in IDLE and DONE.
REQ-022 SHALL abort the current operation when a valid request arrives while busy: go to LOAD next cycle, with no data_resultRDY for the aborted operation.
REQ-023 SHALL assert counter_reset in IDLE, LOAD and DONE, and SHALL NOT assert counter_enable outside the RUN states.

Reset
REQ-024 SHALL, while reset = 1, force state IDLE regardless of clock.
REQ-025 SHALL, while reset = 1, drive counter_reset = 1 and all other outputs to 0.
REQ-026 SHALL, on reset mid-operation, drop busy immediately and never assert data_resultRDY for the interrupted operation.

Configuration
REQ-027 SHALL support the macro MULTDIV_DIVZERO_FAST_EN.
REQ-028 SHALL, when MULTDIV_DIVZERO_FAST_EN is defined, send a divide with latched divisor_zero = 1 from LOAD directly to DONE, skipping DIV_RUN and FIX, with data_exception = 1.
REQ-029 SHALL, when MULTDIV_DIVZERO_FAST_EN is undefined, run a zero-divisor divide through the full DIV_RUN and FIX sequence, then flag data_exception = 1 in DONE.

Structure
REQ-030 SHALL take the state encoding enum, the operation-type constants (OP_MULT, OP_DIV) and the iteration counts (16, 32) from the shared package multdiv_pkg.
REQ-031 SHALL be a single flat module with no sub-module; the iteration counter is instantiated by the parent alongside this block.

Verification
REQ-032 SHALL cover: ctrl_MULT pulse, ovf16 rising after 16 RUN cycles, mult_ovf = 0 -> data_resultRDY pulse 1 cycle after the FIX cycle, data_exception = 0, 19 cycles from request to ready (FIX_CYCLES = 1).
REQ-033 SHALL cover: ctrl_DIV pulse with divisor_zero = 0, ovf32 after 32 RUN cycles -> step_div high for 32 cycles, data_resultRDY 35 cycles after request, data_exception = 0.
REQ-034 SHALL cover: ctrl_DIV with divisor_zero = 1 -> data_exception = 1 at data_resultRDY, 2 cycles after request with MULTDIV_DIVZERO_FAST_EN defined and 35 cycles after request without it.
REQ-035 SHALL cover: ctrl_MULT and ctrl_DIV both pulsed in the same cycle while in IDLE -> busy stays 0, load_operands stays 0.
REQ-036 SHALL cover: ctrl_DIV issued at MULT_RUN cycle 8 -> LOAD next cycle, a divide completes, and exactly one data_resultRDY pulse occurs.
REQ-037 SHALL cover: reset asserted at DIV_RUN cycle 10 -> busy = 0 and counter_reset = 1 in the same cycle, with no data_resultRDY afterwards.
